// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and MEM/WB bundle layout.
package memory_access_pkg;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memState_e;

    localparam int REG_ADDR_W   = 5;
    localparam int MEMWB_CTRL_W = 2;

    // Bundle layout, MSB first: mem_to_reg, reg_wr_en, reg_wr_addr, alu_result, read_data.
    function automatic int memWbWidth(input int dataWidth);
        return MEMWB_CTRL_W + REG_ADDR_W + 2 * dataWidth;
    endfunction

endpackage

// File: rtl/memory_access_mem_wb_reg.sv
// MEM/WB pipeline register bank; a bubble clears the two control bits and holds the rest.
module memory_access_mem_wb_reg
    import memory_access_pkg::*;
#(
    parameter int WIDTH = memWbWidth(32)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] bank_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_q <= '0;
        end else if (bubble_i) begin
            bank_q[WIDTH-1 -: MEMWB_CTRL_W] <= '0;
        end else begin
            bank_q <= d_i;
        end
    end

    assign q_o = bank_q;

endmodule

// File: rtl/memory_access.sv
// Pipeline MEM stage: req/ack data-memory master, stall generation, forwarding and MEM/WB register.
// Define MEM_TIMEOUT_EN to bound the WAIT state and report a bus error after TIMEOUT_CYCLES.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_mem_mem_to_reg_wr,
    input  logic                  ex_mem_mem_wr_en,
    input  logic                  ex_mem_reg_wr_en,
    input  logic [REG_ADDR_W-1:0] ex_mem_reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_mem_mem_wr_data,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic                  mem_stall,
    output logic                  mem_fwd_reg_wr_en,
    output logic [REG_ADDR_W-1:0] mem_fwd_reg_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_fwd_data,
    output logic                  mem_wb_mem_to_reg_wr,
    output logic                  mem_wb_reg_wr_en,
    output logic [REG_ADDR_W-1:0] mem_wb_reg_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wb_alu_result,
    output logic [DATA_WIDTH-1:0] mem_wb_read_data,
    output logic                  mem_bus_err
);

    localparam int MEMWB_W = memWbWidth(DATA_WIDTH);

    memState_e             state_q, state_d;
    logic                  access;
    logic                  timeoutHit;
    logic                  bubble;
    logic [DATA_WIDTH-1:0] readData;
    logic [MEMWB_W-1:0]    memWb_d, memWb_q;

    assign access     = ex_mem_mem_wr_en | ex_mem_mem_to_reg_wr;
    assign dmem_addr  = ex_mem_alu_result;
    assign dmem_wdata = ex_mem_mem_wr_data;
    assign dmem_we    = ex_mem_mem_wr_en;

    assign mem_fwd_reg_wr_en   = ex_mem_reg_wr_en;
    assign mem_fwd_reg_wr_addr = ex_mem_reg_wr_addr;
    assign mem_fwd_data        = ex_mem_alu_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request/stall are gated by reset so an abandoned access drops off the bus immediately.
    always_comb begin
        state_d   = state_q;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        if (reset) begin
            if (state_q == MEM_IDLE) begin
                if (access) begin
                    dmem_req = 1'b1;
                    if (!dmem_ack) begin
                        mem_stall = 1'b1;
                        state_d   = MEM_WAIT;
                    end
                end
            end else begin
                dmem_req = 1'b1;
                if (dmem_ack || timeoutHit) begin
                    state_d = MEM_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic             busErr_q;

    assign timeoutHit = (state_q == MEM_WAIT) && !dmem_ack &&
                        (waitCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        waitCnt_d = '0;
        if (state_q == MEM_WAIT && !dmem_ack) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            waitCnt_q <= '0;
            busErr_q  <= 1'b0;
        end else begin
            waitCnt_q <= waitCnt_d;
            busErr_q  <= timeoutHit;
        end
    end

    assign mem_bus_err = busErr_q;
`else
    assign timeoutHit  = 1'b0;
    assign mem_bus_err = 1'b0;
`endif

    // A timed-out access releases the stall but must not write back.
    assign bubble   = mem_stall | timeoutHit;
    assign readData = (dmem_req && dmem_ack) ? dmem_rdata : '0;
    assign memWb_d  = {ex_mem_mem_to_reg_wr, ex_mem_reg_wr_en, ex_mem_reg_wr_addr,
                       ex_mem_alu_result, readData};

    memory_access_mem_wb_reg #(
        .WIDTH (MEMWB_W)
    ) u_mem_wb_reg (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (bubble),
        .d_i      (memWb_d),
        .q_o      (memWb_q)
    );

    assign {mem_wb_mem_to_reg_wr, mem_wb_reg_wr_en, mem_wb_reg_wr_addr,
            mem_wb_alu_result, mem_wb_read_data} = memWb_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for the memory_access MEM stage (timeout case under MEM_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_memory_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        memToReg, memWr, regWr;
   logic [4:0]  regAddr;
   logic [31:0] aluResult, wrData, rdData;
   logic        ack;

   logic        dmemReq, dmemWe, memStall, fwdWrEn, wbMemToReg, wbWrEn, busErr;
   logic [31:0] dmemAddr, dmemWdata, fwdData, wbAlu, wbRead;
   logic [4:0]  fwdAddr, wbAddr;

   int compareCount  = 0;
   int mismatchCount = 0;

   always #5 clk = ~clk;

   memory_access #(
      .TIMEOUT_CYCLES (4),
      .DATA_WIDTH     (32)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .ex_mem_mem_to_reg_wr (memToReg),
      .ex_mem_mem_wr_en     (memWr),
      .ex_mem_reg_wr_en     (regWr),
      .ex_mem_reg_wr_addr   (regAddr),
      .ex_mem_alu_result    (aluResult),
      .ex_mem_mem_wr_data   (wrData),
      .dmem_rdata           (rdData),
      .dmem_ack             (ack),
      .dmem_req             (dmemReq),
      .dmem_we              (dmemWe),
      .dmem_addr            (dmemAddr),
      .dmem_wdata           (dmemWdata),
      .mem_stall            (memStall),
      .mem_fwd_reg_wr_en    (fwdWrEn),
      .mem_fwd_reg_wr_addr  (fwdAddr),
      .mem_fwd_data         (fwdData),
      .mem_wb_mem_to_reg_wr (wbMemToReg),
      .mem_wb_reg_wr_en     (wbWrEn),
      .mem_wb_reg_wr_addr   (wbAddr),
      .mem_wb_alu_result    (wbAlu),
      .mem_wb_read_data     (wbRead),
      .mem_bus_err          (busErr)
   );

   // Drive one EX/MEM word plus the memory response, then let combinational outputs settle.
   task automatic applyStimulus(input logic mtr, input logic mw, input logic rw,
                                input logic [4:0] ra, input logic [31:0] alu,
                                input logic [31:0] wd, input logic a, input logic [31:0] rd);
      memToReg  = mtr;
      memWr     = mw;
      regWr     = rw;
      regAddr   = ra;
      aluResult = alu;
      wrData    = wd;
      ack       = a;
      rdData    = rd;
      #1;
   endtask

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and sample registered outputs just after the edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("rst_req",      {31'b0, dmemReq},    32'd0);
      checkOutput("rst_stall",    {31'b0, memStall},   32'd0);
      checkOutput("rst_wb_wren",  {31'b0, wbWrEn},     32'd0);
      checkOutput("rst_wb_alu",   wbAlu,               32'd0);
      checkOutput("rst_bus_err",  {31'b0, busErr},     32'd0);
      reset = 1'b1;

      // Zero-wait load
      applyStimulus(1, 0, 1, 5'd5, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);
      checkOutput("zw_req",   {31'b0, dmemReq},  32'd1);
      checkOutput("zw_we",    {31'b0, dmemWe},   32'd0);
      checkOutput("zw_addr",  dmemAddr,          32'h0000_0040);
      checkOutput("zw_stall", {31'b0, memStall}, 32'd0);
      nextCycle();
      checkOutput("zw_wb_rdata", wbRead,                32'hDEAD_BEEF);
      checkOutput("zw_wb_addr",  {27'b0, wbAddr},       32'd5);
      checkOutput("zw_wb_wren",  {31'b0, wbWrEn},       32'd1);
      checkOutput("zw_wb_m2r",   {31'b0, wbMemToReg},   32'd1);
      checkOutput("zw_wb_alu",   wbAlu,                 32'h0000_0040);

      // Plain ALU op; a stray ack without a request must be ignored
      applyStimulus(0, 0, 1, 5'd3, 32'h0000_00FF, 32'h0, 1, 32'hAAAA_AAAA);
      checkOutput("alu_req",   {31'b0, dmemReq},  32'd0);
      checkOutput("alu_stall", {31'b0, memStall}, 32'd0);
      nextCycle();
      checkOutput("alu_wb_alu",   wbAlu,               32'h0000_00FF);
      checkOutput("alu_wb_rdata", wbRead,              32'h0);
      checkOutput("alu_wb_wren",  {31'b0, wbWrEn},     32'd1);
      checkOutput("alu_wb_addr",  {27'b0, wbAddr},     32'd3);

      // Three-wait store, ack on the fourth request cycle
      for (int c = 0; c < 4; c++) begin
         applyStimulus(0, 1, 0, 5'd0, 32'h0000_0010, 32'h1234_5678, (c == 3), 32'h5555_5555);
         checkOutput("st_req",   {31'b0, dmemReq},  32'd1);
         checkOutput("st_we",    {31'b0, dmemWe},   32'd1);
         checkOutput("st_wdata", dmemWdata,         32'h1234_5678);
         checkOutput("st_stall", {31'b0, memStall}, (c < 3) ? 32'd1 : 32'd0);
         nextCycle();
         checkOutput("st_wb_wren", {31'b0, wbWrEn}, 32'd0);
      end
      checkOutput("st_wb_alu",   wbAlu,  32'h0000_0010);
      checkOutput("st_wb_rdata", wbRead, 32'h5555_5555);

      // Load to r7 stalls; forwarding stays valid, then reset abandons it in WAIT
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1, 0, 1, 5'd7, 32'h0000_0080, 32'h0, 0, 32'h0);
         checkOutput("fwd_stall", {31'b0, memStall}, 32'd1);
         checkOutput("fwd_en",    {31'b0, fwdWrEn},  32'd1);
         checkOutput("fwd_addr",  {27'b0, fwdAddr},  32'd7);
         checkOutput("fwd_data",  fwdData,           32'h0000_0080);
         nextCycle();
      end
      reset = 1'b0;
      #1;
      checkOutput("rstw_req",   {31'b0, dmemReq},  32'd0);
      checkOutput("rstw_stall", {31'b0, memStall}, 32'd0);
      nextCycle();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
      checkOutput("rstw_idle_req", {31'b0, dmemReq},  32'd0);
      checkOutput("rstw_wb_m2r",   {31'b0, wbMemToReg}, 32'd0);
      checkOutput("rstw_wb_wren",  {31'b0, wbWrEn},   32'd0);
      checkOutput("rstw_wb_addr",  {27'b0, wbAddr},   32'd0);
      checkOutput("rstw_wb_alu",   wbAlu,             32'd0);
      checkOutput("rstw_wb_rdata", wbRead,            32'd0);

      // Write-enabled ALU op so a later bubble is observable
      applyStimulus(0, 0, 1, 5'd9, 32'h0000_0099, 32'h0, 0, 32'h0);
      nextCycle();
      checkOutput("pre_wb_wren", {31'b0, wbWrEn}, 32'd1);

`ifdef MEM_TIMEOUT_EN
      // No ack: 1 IDLE + 3 WAIT stall cycles, then the 4th WAIT cycle times out
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1, 0, 1, 5'd2, 32'h0000_0200, 32'h0, 0, 32'h0);
         checkOutput("to_req",   {31'b0, dmemReq},  32'd1);
         checkOutput("to_stall", {31'b0, memStall}, (c < 4) ? 32'd1 : 32'd0);
         checkOutput("to_err_lo", {31'b0, busErr},  32'd0);
         nextCycle();
      end
      checkOutput("to_err_pulse", {31'b0, busErr}, 32'd1);
      checkOutput("to_wb_wren",   {31'b0, wbWrEn}, 32'd0);
      applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
      nextCycle();
      checkOutput("to_err_clr", {31'b0, busErr}, 32'd0);
`else
      // Without the timeout, a long wait simply stalls until ack
      for (int c = 0; c < 9; c++) begin
         applyStimulus(1, 0, 1, 5'd2, 32'h0000_0200, 32'h0, (c == 8), 32'hCAFE_0001);
         checkOutput("lw_stall", {31'b0, memStall}, (c < 8) ? 32'd1 : 32'd0);
         checkOutput("lw_err",   {31'b0, busErr},   32'd0);
         nextCycle();
      end
      checkOutput("lw_wb_rdata", wbRead,           32'hCAFE_0001);
      checkOutput("lw_wb_wren",  {31'b0, wbWrEn},  32'd1);
      checkOutput("lw_wb_addr",  {27'b0, wbAddr},  32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline MEM stage. Sits directly downstream of the EX stage and consumes its EX/MEM register outputs.
- Drives a req/ack data-memory bus and generates a stall while a load or store is outstanding.
- Provides MEM-stage forwarding values to the hazard unit.
- Registers MEM/WB pipeline state for the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of WAIT cycles before bus error (only used with MEM_TIMEOUT_EN)
- DATA_WIDTH, 32, data and address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- ex_mem_mem_to_reg_wr  in  1  load indicator (writeback selects memory data)
- ex_mem_mem_wr_en  in  1  store indicator
- ex_mem_reg_wr_en  in  1  register-file write enable
- ex_mem_reg_wr_addr  in  5  destination register
- ex_mem_alu_result  in  DATA_WIDTH  effective address / ALU result
- ex_mem_mem_wr_data  in  DATA_WIDTH  store data
- dmem_rdata  in  DATA_WIDTH  memory read data, valid when dmem_ack=1
- dmem_ack  in  1  memory completion strobe
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_WIDTH  memory address
- dmem_wdata  out  DATA_WIDTH  memory write data
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
- mem_fwd_reg_wr_en  out  1  forwarding: MEM-stage write enable
- mem_fwd_reg_wr_addr  out  5  forwarding: MEM-stage destination register
- mem_fwd_data  out  DATA_WIDTH  forwarding: ex_mem_alu_result
- mem_wb_mem_to_reg_wr  out  1  registered
- mem_wb_reg_wr_en  out  1  registered
- mem_wb_reg_wr_addr  out  5  registered
- mem_wb_alu_result  out  DATA_WIDTH  registered
- mem_wb_read_data  out  DATA_WIDTH  registered
- mem_bus_err  out  1  registered one-cycle timeout pulse

Behaviour:
- Access condition: access = ex_mem_mem_wr_en | ex_mem_mem_to_reg_wr.
- Bus outputs:
  - dmem_addr = ex_mem_alu_result; dmem_wdata = ex_mem_mem_wr_data; dmem_we = ex_mem_mem_wr_en. All combinational.
  - If both access flags are set, the access is treated as a store and mem_to_reg is passed through unchanged.
- FSM states IDLE and WAIT; reset state is IDLE.
- IDLE, no access:
  - dmem_req=0, mem_stall=0.
  - MEM/WB captures the EX/MEM fields, mem_wb_read_data <= 0.
- IDLE, access:
  - dmem_req=1 (combinational).
  - If dmem_ack=1 in the same cycle: mem_stall=0, MEM/WB captures with mem_wb_read_data <= dmem_rdata, stay in IDLE (zero-wait access).
  - Else: mem_stall=1, go to WAIT.
- WAIT:
  - dmem_req=1, mem_stall=1, address, data and we held stable, because upstream is frozen by mem_stall.
  - On dmem_ack=1: mem_stall=0, capture as in the zero-wait case, go to IDLE.
- Stall cycles: every cycle with mem_stall=1 loads a bubble into MEM/WB (reg_wr_en=0, mem_to_reg_wr=0; other fields don't-care, implemented as hold).
- Latency: minimum 1 clock from EX/MEM to MEM/WB; each ack wait cycle adds 1.
- dmem_ack while dmem_req=0 is ignored.
- Forwarding outputs are combinational pass-throughs of the EX/MEM fields, valid even during stall.
- Reset:
  - While reset=0, dmem_req and mem_stall are forced to 0.
  - On the next clock edge: FSM -> IDLE, all mem_wb_* outputs -> 0, mem_bus_err -> 0, timeout counter -> 0.
  - Reset asserted in WAIT abandons the access with no MEM/WB write.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: mem_bus_err pulses 1 for one cycle next cycle, FSM -> IDLE, mem_stall=0 that cycle, and MEM/WB loads a bubble (reg_wr_en=0).
  - Ack and timeout in the same cycle: ack wins.
- Undefined: WAIT is unbounded, no counter logic exists, mem_bus_err is tied to 0.

Decomposition:
- Shared package:
  - State encoding (MEM_IDLE=1'b0, MEM_WAIT=1'b1).
  - REG_ADDR_W=5.
  - MEM/WB bundle width constant.
- One sub-module is natural: mem_wb_reg, the MEM/WB register bank with synchronous active-low reset and a bubble input.

Test Plan:
- Zero-wait load: alu_result=0x0000_0040, mem_to_reg=1, reg_wr_en=1, addr=5, ack same cycle with rdata=0xDEAD_BEEF -> mem_stall stays 0; next cycle mem_wb_read_data=0xDEAD_BEEF, mem_wb_reg_wr_addr=5, mem_wb_reg_wr_en=1.
- Three-wait store: mem_wr_en=1, addr=0x10, wdata=0x1234_5678, ack on 4th cycle -> dmem_req=1, we=1 for 4 cycles; mem_stall=1 for 3 cycles; mem_wb_reg_wr_en=0 throughout.
- Non-memory ALU op: reg_wr_en=1, alu_result=0x0000_00FF -> dmem_req=0; next cycle mem_wb_alu_result=0xFF, mem_wb_read_data=0.
- Reset in WAIT: load pending 2 cycles, reset=0 for 1 cycle -> dmem_req and mem_stall drop immediately; after the edge, state IDLE and all mem_wb_* outputs = 0.
- Forwarding during stall: load to r7 waiting -> mem_fwd_reg_wr_addr=7 and mem_fwd_data=alu_result held every stall cycle.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4: load with no ack -> mem_bus_err pulses once after 4 WAIT cycles, mem_stall releases, mem_wb_reg_wr_en=0.
